axis_frame_src: RTL and testbench
=================================

Name: axis_frame_src

Overview:
Synthesizable AXI4-Stream frame transmitter. It generates framed complex test vectors, [im, re], for driving the OSPFB/FFT data path on hardware and in simulation. It is the transmit counterpart of the capture VIP: it honours full tready backpressure, marks frame ends with tlast, and tags each beat with its in-frame index on tuser. A fixed run of frames starts on a start pulse; NUM_FRAMES=0 means run until stopped.

Parameters:
WIDTH, 16, bits per real/imag component; tdata is 2*WIDTH
FRAME_LEN, 64, beats per frame; must be ≥2
NUM_FRAMES, 0, frames per run; 0 = unbounded
AMP, 2**(WIDTH-2), amplitude for impulse/DC/Nyquist modes
IMP_IDX, 0, in-frame index of the impulse; must be < FRAME_LEN
USER_WID, 8, tuser width; must be ≥ clog2(FRAME_LEN)

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  reset; asynchronous assert, active-low
start  in  1  one-cycle pulse; begins a run when IDLE or DONE
stop  in  1  level; ends the run at the next frame boundary
mode  in  2  pattern select, sampled on start: 0 ramp, 1 impulse, 2 DC, 3 Nyquist
m_axis  axis.MST  2*WIDTH  tdata = {im, re}, with tvalid/tready
m_axis_tlast  out  1  high on beat FRAME_LEN-1 of each frame
m_axis_tuser  out  USER_WID  in-frame beat index, zero-extended
frame_cnt  out  32  frames fully transferred since the last start
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE. tvalid=0, tdata=0, tlast=0, tuser=0, frame_cnt=0, busy=0, done=0, beat index=0, latched mode=0.
- All outputs are registered. Each accepted beat is the cycle where tvalid&&tready is high at the clk edge.
- FSM:
  - IDLE --start--> RUN. On that edge: latch mode, clear frame_cnt and beat index, present beat 0 with tvalid=1. First beat is valid 1 cycle after start.
  - RUN: on each accepted beat, advance the beat index. Index wraps FRAME_LEN-1 -> 0. On the tlast beat, frame_cnt increments.
  - RUN -> DONE on acceptance of the tlast beat when either:
    - frame_cnt+1 == NUM_FRAMES (NUM_FRAMES≠0), or
    - the stop latch is set.
    stop is latched while in RUN and cleared on entry to DONE.
  - DONE: tvalid=0, done=1. start -> RUN exactly as from IDLE.
- AXIS rules:
  - Once tvalid=1, tdata/tlast/tuser hold until accepted. tvalid never drops before acceptance.
  - Next beat is presented in the same cycle as acceptance. Sustains 1 beat/cycle with tready held high.
  - tvalid does not depend combinationally on tready.
- Patterns, with n = beat index and f = frame_cnt:
  - ramp: re=n, im=f[WIDTH-1:0].
  - impulse: re=AMP when n==IMP_IDX, else 0; im=0.
  - DC: re=AMP, im=0.
  - Nyquist: re=+AMP when n is even, -AMP when n is odd (two's complement); im=0.
- start while RUN: ignored. mode changes while RUN: ignored.
- stop and start in the same cycle while IDLE: start wins, and stop is not latched.
- stop asserted in IDLE/DONE: no effect.
- Reset mid-frame: immediate return to IDLE with tvalid=0. The partial frame is abandoned, and the downstream sink must expect a truncated frame.
- frame_cnt wraps modulo 2**32, with no saturation.

Decomposition:
- Shared package (ospfb_pkg): mode enum (MODE_RAMP, MODE_IMPULSE, MODE_DC, MODE_NYQ) and FSM state enum (IDLE, RUN, DONE).
- One sub-module, frame_pattern_gen: combinational tdata from mode, n, f. Its output is registered in axis_frame_src.
- Counter and FSM stay in the top.

Test Plan:
1. FRAME_LEN=8, NUM_FRAMES=2, ramp, tready=1:
   - tvalid first high 1 cycle after start.
   - 16 beats back-to-back; re=0..7, im=0 then im=1.
   - tlast on beats 7 and 15; done=1 after beat 15; frame_cnt=2.
2. Random tready (50%), ramp, FRAME_LEN=8, NUM_FRAMES=3:
   - tdata/tlast/tuser stable while tvalid&&!tready.
   - No dropped or duplicated beats; captured sequence identical to scenario 1 extended to 3 frames.
3. Impulse, IMP_IDX=3, WIDTH=16: re=16384 only at tuser=3 in every frame, all other re/im=0. Nyquist: re alternates 16384/-16384 starting +.
4. NUM_FRAMES=0, stop pulsed at beat 2 of frame 4: run continues through beat 7 of frame 4, then DONE with frame_cnt=5. No beats after that tlast.
5. rst_n low at beat 5 of frame 1, asynchronous and mid-cycle:
   - tvalid=0 and frame_cnt=0 immediately.
   - After release and start, beat 0 of frame 0 is re-sent.
6. start during RUN and mode change during RUN: no restart, pattern unchanged. start in DONE with a new mode: new run in the new mode, frame_cnt restarts at 0.

Source files
------------

// File: rtl/ospfb_pkg.sv
// Shared types for the OSPFB test-vector source: pattern modes and frame FSM states.
package ospfb_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP    = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_DC      = 2'd2,
    MODE_NYQ     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of an in-frame beat index; never narrower than one bit.
  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/frame_pattern_gen.sv
// Combinational pattern generator: tdata = {im, re} for a given mode, beat index n and frame f.
module frame_pattern_gen
  import ospfb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int AMP     = 2**(WIDTH-2),
  parameter int IMP_IDX = 0,
  parameter int IDX_W   = 6
) (
  input  mode_e              mode,
  input  logic [IDX_W-1:0]   n,
  input  logic [WIDTH-1:0]   f,
  output logic [2*WIDTH-1:0] tdata
);

  localparam logic [WIDTH-1:0] AMP_POS = WIDTH'(AMP);
  localparam logic [WIDTH-1:0] AMP_NEG = WIDTH'(-AMP);

  logic [WIDTH-1:0] re;
  logic [WIDTH-1:0] im;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    re = '0;
    im = '0;
    case (mode)
      MODE_RAMP: begin
        re = WIDTH'(n);
        im = f;
      end
      MODE_IMPULSE: re = (n == IDX_W'(IMP_IDX)) ? AMP_POS : '0;
      MODE_DC:      re = AMP_POS;
      MODE_NYQ:     re = n[0] ? AMP_NEG : AMP_POS;
      default:      ;
    endcase
  end

  assign tdata = {im, re};

endmodule

// File: rtl/axis_frame_src.sv
// AXI4-Stream framed test-vector transmitter with full backpressure, tlast framing and tuser beat index.
module axis_frame_src
  import ospfb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAME_LEN  = 64,
  parameter int NUM_FRAMES = 0,
  parameter int AMP        = 2**(WIDTH-2),
  parameter int IMP_IDX    = 0,
  parameter int USER_WID   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  output logic [2*WIDTH-1:0]  m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [USER_WID-1:0] m_axis_tuser,
  output logic [31:0]         frame_cnt,
  output logic                busy,
  output logic                done
);

  localparam int              IDX_W      = idx_width(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [31:0]     NUM_FRM_W  = 32'(NUM_FRAMES);
  localparam bit              BOUNDED    = (NUM_FRAMES != 0);

  state_e             state;
  mode_e              mode_q;
  logic               stop_q;
  logic [IDX_W-1:0]   beat_idx;

  logic               accept;
  logic               frame_end;
  logic               run_end;
  logic [IDX_W-1:0]   idx_nxt;
  logic [31:0]        fcnt_nxt;

  mode_e              gen_mode;
  logic [IDX_W-1:0]   gen_n;
  logic [WIDTH-1:0]   gen_f;
  logic [2*WIDTH-1:0] gen_data;

  assign accept    = (state == RUN) && m_axis_tvalid && m_axis_tready;
  assign frame_end = accept && m_axis_tlast;
  assign idx_nxt   = (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);
  assign fcnt_nxt  = frame_end ? frame_cnt + 32'd1 : frame_cnt;
  assign run_end   = frame_end && (stop_q || (BOUNDED && (fcnt_nxt == NUM_FRM_W)));

  // The generator always computes the beat that will be presented after this edge.
  always_comb begin
    gen_mode = mode_q;
    gen_n    = idx_nxt;
    gen_f    = fcnt_nxt[WIDTH-1:0];
    if (state != RUN) begin
      gen_mode = mode_e'(mode);
      gen_n    = '0;
      gen_f    = '0;
    end
  end

  frame_pattern_gen #(
    .WIDTH   (WIDTH),
    .AMP     (AMP),
    .IMP_IDX (IMP_IDX),
    .IDX_W   (IDX_W)
  ) u_pattern (
    .mode  (gen_mode),
    .n     (gen_n),
    .f     (gen_f),
    .tdata (gen_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= MODE_RAMP;
      stop_q        <= 1'b0;
      beat_idx      <= '0;
      frame_cnt     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            mode_q        <= mode_e'(mode);
            stop_q        <= 1'b0;
            beat_idx      <= '0;
            frame_cnt     <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= gen_data;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end
        RUN: begin
          if (stop) stop_q <= 1'b1;
          if (accept) begin
            frame_cnt <= fcnt_nxt;
            beat_idx  <= idx_nxt;
            if (run_end) begin
              state         <= DONE;
              stop_q        <= 1'b0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              m_axis_tdata <= gen_data;
              m_axis_tlast <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis_tuser = USER_WID'(beat_idx);

endmodule

// File: tb/tb_axis_frame_src.sv
// Self-checking bench for axis_frame_src: table-driven pattern vectors plus directed run/stop/reset sequences.
module tb_axis_frame_src;
  import ospfb_pkg::*;

  localparam int WIDTH    = 16;
  localparam int DW       = 2 * WIDTH;
  localparam int FLEN     = 8;
  localparam int USER_WID = 8;

  typedef struct packed {
    logic [DW-1:0]       data;
    logic                last;
    logic [USER_WID-1:0] user;
  } beat_t;

  typedef struct {
    mode_e               mode;
    int                  pos;
    logic [DW-1:0]       data;
    logic                last;
    logic [USER_WID-1:0] user;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance A: NUM_FRAMES=2; instance B: unbounded, ended with stop.
  logic                a_start = 0, a_stop = 0, a_ready = 1;
  logic [1:0]          a_mode = 0;
  logic [DW-1:0]       a_data;
  logic                a_valid, a_last, a_busy, a_done;
  logic [USER_WID-1:0] a_user;
  logic [31:0]         a_fc;

  logic                b_start = 0, b_stop = 0, b_ready = 1, b_rand = 0;
  logic [1:0]          b_mode = 0;
  logic [DW-1:0]       b_data;
  logic                b_valid, b_last, b_busy, b_done;
  logic [USER_WID-1:0] b_user;
  logic [31:0]         b_fc;

  logic sel = 1'b0;
  logic obs_valid, obs_ready, obs_done, obs_busy;
  beat_t obs_beat;
  logic [31:0] obs_fc;

  int checks = 0;
  int failures = 0;
  beat_t cap[$];

  always #5 clk = ~clk;

  axis_frame_src #(
    .WIDTH(WIDTH), .FRAME_LEN(FLEN), .NUM_FRAMES(2), .IMP_IDX(3), .USER_WID(USER_WID)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .mode(a_mode),
    .m_axis_tdata(a_data), .m_axis_tvalid(a_valid), .m_axis_tready(a_ready),
    .m_axis_tlast(a_last), .m_axis_tuser(a_user), .frame_cnt(a_fc),
    .busy(a_busy), .done(a_done)
  );

  axis_frame_src #(
    .WIDTH(WIDTH), .FRAME_LEN(FLEN), .NUM_FRAMES(0), .IMP_IDX(3), .USER_WID(USER_WID)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .mode(b_mode),
    .m_axis_tdata(b_data), .m_axis_tvalid(b_valid), .m_axis_tready(b_ready),
    .m_axis_tlast(b_last), .m_axis_tuser(b_user), .frame_cnt(b_fc),
    .busy(b_busy), .done(b_done)
  );

  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_done  = sel ? b_done  : a_done;
  assign obs_busy  = sel ? b_busy  : a_busy;
  assign obs_fc    = sel ? b_fc    : a_fc;
  assign obs_beat  = sel ? {b_data, b_last, b_user} : {a_data, a_last, a_user};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge: capture accepted beats and enforce hold-under-backpressure.
  logic  pend = 1'b0;
  beat_t pend_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) check("hold", {obs_valid, obs_beat}, {1'b1, pend_b});
      pend   = obs_valid && !obs_ready;
      pend_b = obs_beat;
      if (obs_valid && obs_ready) cap.push_back(obs_beat);
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_rand) b_ready = 1'($urandom_range(0, 1));
  end

  function automatic beat_t ramp_beat(input int i);
    beat_t b;
    b.data = {16'(i / FLEN), 16'(i % FLEN)};
    b.last = ((i % FLEN) == FLEN - 1);
    b.user = USER_WID'(i % FLEN);
    return b;
  endfunction

  function automatic beat_t cap_at(input int i);
    return (i < cap.size()) ? cap[i] : '1;
  endfunction

  task automatic check_ramp(input string name, input int nbeats);
    check({name, "_count"}, 64'(cap.size()), 64'(nbeats));
    for (int i = 0; i < nbeats; i++)
      check($sformatf("%s_beat%0d", name, i), cap_at(i), ramp_beat(i));
  endtask

  task automatic start_run(input mode_e m, input logic with_stop);
    @(posedge clk); #2;
    if (sel) begin b_start = 1; b_mode = m; b_stop = with_stop; end
    else     begin a_start = 1; a_mode = m; a_stop = with_stop; end
    @(posedge clk); #2;
    a_start = 0; b_start = 0; a_stop = 0; b_stop = 0;
    check("first_valid", obs_valid, 1);
    check("start_fcnt", obs_fc, 0);
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (cap.size() >= n) break;
    end
    check($sformatf("reach_%0d_beats", n), 64'(cap.size() >= n), 1);
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (obs_done) break;
    end
    check("done_reached", obs_done, 1);
  endtask

  task automatic run_a(input mode_e m);
    sel = 0;
    cap.delete();
    start_run(m, 1'b0);
    wait_done(100);
    check("run_a_count", 64'(cap.size()), 16);
    check("run_a_fcnt", a_fc, 2);
    check("run_a_idle_bus", {a_valid, a_busy}, 0);
  endtask

  vec_t  vecs[18];
  mode_e run_mode;
  bit    have_run;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MODE_RAMP,    0,  32'h0000_0000, 1'b0, 8'd0};
    vecs[1]  = '{MODE_RAMP,    5,  32'h0000_0005, 1'b0, 8'd5};
    vecs[2]  = '{MODE_RAMP,    7,  32'h0000_0007, 1'b1, 8'd7};
    vecs[3]  = '{MODE_RAMP,    8,  32'h0001_0000, 1'b0, 8'd0};
    vecs[4]  = '{MODE_RAMP,    15, 32'h0001_0007, 1'b1, 8'd7};
    vecs[5]  = '{MODE_IMPULSE, 2,  32'h0000_0000, 1'b0, 8'd2};
    vecs[6]  = '{MODE_IMPULSE, 3,  32'h0000_4000, 1'b0, 8'd3};
    vecs[7]  = '{MODE_IMPULSE, 4,  32'h0000_0000, 1'b0, 8'd4};
    vecs[8]  = '{MODE_IMPULSE, 11, 32'h0000_4000, 1'b0, 8'd3};
    vecs[9]  = '{MODE_IMPULSE, 15, 32'h0000_0000, 1'b1, 8'd7};
    vecs[10] = '{MODE_DC,      0,  32'h0000_4000, 1'b0, 8'd0};
    vecs[11] = '{MODE_DC,      9,  32'h0000_4000, 1'b0, 8'd1};
    vecs[12] = '{MODE_DC,      15, 32'h0000_4000, 1'b1, 8'd7};
    vecs[13] = '{MODE_NYQ,     0,  32'h0000_4000, 1'b0, 8'd0};
    vecs[14] = '{MODE_NYQ,     1,  32'h0000_C000, 1'b0, 8'd1};
    vecs[15] = '{MODE_NYQ,     8,  32'h0000_4000, 1'b0, 8'd0};
    vecs[16] = '{MODE_NYQ,     14, 32'h0000_4000, 1'b0, 8'd6};
    vecs[17] = '{MODE_NYQ,     15, 32'h0000_C000, 1'b1, 8'd7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ctrl", {a_valid, a_last, a_user, a_busy, a_done}, 0);
    check("rst_a_data", a_data, 0);
    check("rst_a_fcnt", a_fc, 0);
    check("rst_b_ctrl", {b_valid, b_last, b_user, b_busy, b_done}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Pattern table on instance A with tready held high
    have_run = 0;
    for (int i = 0; i < 18; i++) begin
      if (!have_run || vecs[i].mode != run_mode) begin
        run_a(vecs[i].mode);
        run_mode = vecs[i].mode;
        have_run = 1;
      end
      check($sformatf("vec%0d", i), cap_at(vecs[i].pos), {vecs[i].data, vecs[i].last, vecs[i].user});
    end

    // Random backpressure, three frames ended by stop during frame 2
    sel = 1;
    b_rand = 1;
    cap.delete();
    start_run(MODE_RAMP, 1'b0);
    wait_beats(18, 300);
    b_stop = 1; @(posedge clk); #2 b_stop = 0;
    wait_done(300);
    check_ramp("rand_ready", 24);
    check("rand_ready_fcnt", b_fc, 3);
    b_rand = 0;
    b_ready = 1;

    // Unbounded run: stop with start is ignored, stop at beat 2 of frame 4 ends after frame 4
    cap.delete();
    start_run(MODE_RAMP, 1'b1);
    wait_beats(34, 200);
    b_stop = 1; @(posedge clk); #2 b_stop = 0;
    wait_done(100);
    check_ramp("stop_run", 40);
    check("stop_run_fcnt", b_fc, 5);
    b_stop = 1; @(posedge clk); #2 b_stop = 0;
    repeat (5) @(posedge clk);
    #2;
    check("after_done_count", 64'(cap.size()), 40);
    check("after_done_state", {b_valid, b_busy, b_done}, 3'b001);

    // Asynchronous reset mid-frame, then a clean rerun
    sel = 0;
    cap.delete();
    start_run(MODE_RAMP, 1'b0);
    wait_beats(13, 100);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", {a_valid, a_busy}, 0);
    check("midrst_fcnt", a_fc, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    cap.delete();
    start_run(MODE_RAMP, 1'b0);
    wait_done(100);
    check_ramp("rerun", 16);

    // start and mode change during RUN are ignored
    cap.delete();
    start_run(MODE_RAMP, 1'b0);
    wait_beats(3, 50);
    a_start = 1; a_mode = MODE_NYQ;
    @(posedge clk); #2 a_start = 0;
    wait_done(100);
    check_ramp("no_restart", 16);
    check("no_restart_fcnt", a_fc, 2);

    // start from DONE with a new mode
    cap.delete();
    start_run(MODE_DC, 1'b0);
    wait_done(100);
    check("dc_restart_count", 64'(cap.size()), 16);
    check("dc_restart_first", cap_at(0), {32'h0000_4000, 1'b0, 8'd0});
    check("dc_restart_last", cap_at(15), {32'h0000_4000, 1'b1, 8'd7});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
